hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; all state is updated on this edge.
REQ-002 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have ports: id_valid  in  1  ID holds a real (non-bubble) instruction.
REQ-004 SHALL have ports: id_src1, id_src2  in  4 each  ID source register numbers.
REQ-005 SHALL have ports: id_rd1, id_rd2  in  1 each  the ID instruction actually reads src1 / src2.
REQ-006 SHALL have ports: id_dst  in  4, id_wr  in  1  ID destination register and its write enable.
REQ-007 SHALL have ports: id_load  in  1, id_setflags  in  1, id_usesflags  in  1  ID is LW; ID writes flags; ID is a conditional B/BR.
REQ-008 SHALL have ports: br_taken  in  1  branch resolved taken in ID.
REQ-009 SHALL have ports: mem_busy  in  1  data memory multi-cycle access in progress.
REQ-010 SHALL have ports: stall_pc, stall_ifid  out  1 each  hold PC and IF/ID.
REQ-011 SHALL have ports: bubble_idex  out  1  load a NOP into ID/EX.
REQ-012 SHALL have ports: flush_ifid  out  1  squash the fetched instruction.
REQ-013 SHALL have ports: freeze  out  1  hold every pipeline register.
REQ-014 SHALL have ports: fwd_a, fwd_b  out  2 each  EX operand select: 00 = regfile, 01 = EX/MEM, 10 = MEM/WB.
REQ-015 SHALL have ports: stall_cnt  out  16  count of hazard stall cycles.

Function
REQ-016 SHALL keep a 2-entry scoreboard, EXs and MEMs; each entry holds {valid, dst, wr, load, setflags}.
REQ-017 advance = ~freeze; on advance: MEMs <= EXs; EXs <= ID fields when id_valid & ~hz, else invalid (bubble).
REQ-018 RAW match(s) = entry.valid & entry.wr & entry.dst == s & s != 0; register 0 never hazards.
REQ-019 load-use hz = id_valid & (id_rd1 & match(id_src1) | id_rd2 & match(id_src2)) against EXs with EXs.load.
REQ-020 flag hz = id_valid & id_usesflags & EXs.valid & EXs.setflags.
REQ-021 hz SHALL drive stall_pc = stall_ifid = bubble_idex = 1, combinationally in the same cycle.
REQ-022 Each hz SHALL last exactly 1 cycle, since the entry then moves to MEMs.
REQ-023 freeze = mem_busy; freeze dominates: while asserted, the scoreboard holds and bubble_idex = 0.
REQ-024 While freeze is asserted, stall_pc and stall_ifid SHALL be 1.
REQ-025 flush_ifid = id_valid & br_taken & ~hz & ~freeze; a branch waiting on flags SHALL NOT flush until the stall clears.
REQ-026 fwd_a/fwd_b SHALL be registered on advance from the ID sources: 01 if EXs matches, else 10 if MEMs matches, else 00.
REQ-027 EX/MEM forwarding takes priority over MEM/WB.
REQ-028 fwd SHALL be 00 on a bubble and SHALL hold while frozen.
REQ-029 WB-to-ID is covered by the register-file internal bypass; this block emits no select for it.
REQ-030 stall_cnt SHALL increment in every cycle with hz & ~freeze, and saturate at 16'hFFFF.

Reset
REQ-031 On rst, scoreboard entries SHALL be invalid, fwd_a = fwd_b = 00, and stall_cnt = 0.
REQ-032 Outputs stall_pc, stall_ifid, bubble_idex, flush_ifid and freeze SHALL then follow inputs only.
REQ-033 Reset mid-stall or mid-freeze SHALL discard all pending state at that edge.

Configuration
REQ-034 Macro HAZARD_FWD_EN defined: behaviour SHALL be as REQ-026 to REQ-028.
REQ-035 HAZARD_FWD_EN undefined: fwd_a = fwd_b = 00 always.
REQ-036 HAZARD_FWD_EN undefined: hz SHALL additionally assert on any RAW match against EXs or MEMs, regardless of load, giving stalls of up to 2 cycles.

Verification
REQ-037 Scenario: LW R3 in EX, ID = ADD R4,R3,R5 -> stall/bubble for 1 cycle, stall_cnt 0 -> 1; next cycle fwd_a = 10.
REQ-038 Scenario: ADD R2 in EX, ID = SUB reading R2 as src2 -> no stall; after advance fwd_b = 01 (FWD_EN) or 2 stall cycles with fwd_b = 00 (no FWD_EN).
REQ-039 Scenario: ADD R0 in EX, ID reads R0 -> no stall, fwd = 00.
REQ-040 Scenario: ADD (setflags) in EX, ID = B taken -> cycle 1 stall with flush_ifid = 0; cycle 2 flush_ifid = 1.
REQ-041 Scenario: mem_busy held 3 cycles during a load-use -> freeze = 1 and bubble_idex = 0 for 3 cycles, scoreboard unchanged, then a 1-cycle hz.
REQ-042 Scenario: rst asserted during an hz cycle -> next cycle no stall, fwd = 00, stall_cnt = 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection, stall/flush/freeze and EX operand forwarding
// Optional feature macro: HAZARD_FWD_EN (EX forwarding selects; without it every RAW stalls)
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_rd1,
    input  logic        id_rd2,
    input  logic [3:0]  id_dst,
    input  logic        id_wr,
    input  logic        id_load,
    input  logic        id_setflags,
    input  logic        id_usesflags,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        bubble_idex,
    output logic        flush_ifid,
    output logic        freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    // EX-stage scoreboard entry
    logic       exValid;
    logic [3:0] exDst;
    logic       exWr;
    logic       exLoad;
    logic       exSetFlags;

    // MEM-stage entry: load/setflags only influence hazards while in EX, so only RAW fields remain
    logic       memValid;
    logic [3:0] memDst;
    logic       memWr;

    logic hitEx1, hitEx2, hitMem1, hitMem2;
    logic loadHz, flagHz, rawHz, hz, advance, issue;
    logic [15:0] stallCntQ;

    function automatic logic rawHit(input logic v, input logic w, input logic [3:0] d,
                                    input logic [3:0] s);
        return v & w & (d == s) & (s != 4'd0);
    endfunction

    always_comb begin
        hitEx1  = rawHit(exValid, exWr, exDst, id_src1);
        hitEx2  = rawHit(exValid, exWr, exDst, id_src2);
        hitMem1 = rawHit(memValid, memWr, memDst, id_src1);
        hitMem2 = rawHit(memValid, memWr, memDst, id_src2);
    end

    always_comb begin
        loadHz = id_valid & exLoad & ((id_rd1 & hitEx1) | (id_rd2 & hitEx2));
        flagHz = id_valid & id_usesflags & exValid & exSetFlags;
`ifdef HAZARD_FWD_EN
        rawHz  = 1'b0;
`else
        rawHz  = id_valid & ((id_rd1 & (hitEx1 | hitMem1)) | (id_rd2 & (hitEx2 | hitMem2)));
`endif
        hz      = loadHz | flagHz | rawHz;
        advance = ~mem_busy;
        issue   = id_valid & ~hz;
    end

    always_comb begin
        freeze      = mem_busy;
        stall_pc    = hz | mem_busy;
        stall_ifid  = hz | mem_busy;
        bubble_idex = hz & ~mem_busy;
        flush_ifid  = id_valid & br_taken & ~hz & ~mem_busy;
        stall_cnt   = stallCntQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exValid    <= 1'b0;
            exDst      <= 4'd0;
            exWr       <= 1'b0;
            exLoad     <= 1'b0;
            exSetFlags <= 1'b0;
            memValid   <= 1'b0;
            memDst     <= 4'd0;
            memWr      <= 1'b0;
            stallCntQ  <= 16'd0;
        end else begin
            if (advance) begin
                memValid   <= exValid;
                memDst     <= exDst;
                memWr      <= exWr;
                exValid    <= issue;
                exDst      <= issue ? id_dst : 4'd0;
                exWr       <= issue & id_wr;
                exLoad     <= issue & id_load;
                exSetFlags <= issue & id_setflags;
            end
            if (hz && advance && stallCntQ != 16'hFFFF) begin
                stallCntQ <= stallCntQ + 16'd1;
            end
        end
    end

`ifdef HAZARD_FWD_EN
    logic [1:0] fwdAQ, fwdBQ;

    function automatic logic [1:0] fwdSel(input logic ex, input logic mem);
        return ex ? 2'b01 : (mem ? 2'b10 : 2'b00);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            fwdAQ <= 2'b00;
            fwdBQ <= 2'b00;
        end else if (advance) begin
            fwdAQ <= issue ? fwdSel(hitEx1, hitMem1) : 2'b00;
            fwdBQ <= issue ? fwdSel(hitEx2, hitMem2) : 2'b00;
        end
    end

    always_comb begin
        fwd_a = fwdAQ;
        fwd_b = fwdBQ;
    end
`else
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl, directed vectors for both HAZARD_FWD_EN builds
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1, id_src2, id_dst;
    logic        id_rd1, id_rd2, id_wr, id_load, id_setflags, id_usesflags;
    logic        br_taken, mem_busy;
    logic        stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic        st;
        logic        bub;
        logic        fl;
        logic        fz;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } expT;

    expT expQ[$];
    int  nCompared   = 0;
    int  nMismatched = 0;
    int  cycNo       = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load), .id_setflags(id_setflags),
        .id_usesflags(id_usesflags), .br_taken(br_taken), .mem_busy(mem_busy),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input int act, input int req);
        nCompared++;
        if (act != req) begin
            nMismatched++;
            $display("FAIL cycle %0d %s: got %0d expected %0d", cycNo, name, act, req);
        end
    endtask

    // Monitor: every checked cycle's expectation is popped and compared mid-cycle
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            check("stall_pc",    int'(stall_pc),    int'(e.st));
            check("stall_ifid",  int'(stall_ifid),  int'(e.st));
            check("bubble_idex", int'(bubble_idex), int'(e.bub));
            check("flush_ifid",  int'(flush_ifid),  int'(e.fl));
            check("freeze",      int'(freeze),      int'(e.fz));
            check("fwd_a",       int'(fwd_a),       int'(e.fa));
            check("fwd_b",       int'(fwd_b),       int'(e.fb));
            check("stall_cnt",   int'(stall_cnt),   int'(e.cnt));
        end
    end

    task automatic idIn(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic r1, input logic r2, input logic [3:0] d, input logic w,
                        input logic ld, input logic sf, input logic uf, input logic bt);
        id_valid = v;   id_src1 = s1;  id_src2 = s2;   id_rd1 = r1;      id_rd2 = r2;
        id_dst = d;     id_wr = w;     id_load = ld;   id_setflags = sf; id_usesflags = uf;
        br_taken = bt;
    endtask

    task automatic nop();
        idIn(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cy(input logic mb, input logic r, input logic st, input logic bub,
                      input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [15:0] cnt);
        expT e;
        mem_busy = mb;
        rst      = r;
        e = '{st: st, bub: bub, fl: fl, fz: mb, fa: fa, fb: fb, cnt: cnt};
        expQ.push_back(e);
        @(posedge clk);
        #1;
        cycNo++;
    endtask

    task automatic rstPulse();
        nop();
        mem_busy = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycNo++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nop();
        mem_busy = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        nop(); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);

        // Load-use: LW R3, then ADD R4,R3,R5
        rstPulse();
        idIn(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        idIn(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0); cy(0, 0, 1, 1, 0, 2'b00, 2'b00, 16'd0);
`ifdef HAZARD_FWD_EN
        cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd1);
        nop(); cy(0, 0, 0, 0, 0, 2'b10, 2'b00, 16'd1);
`else
        cy(0, 0, 1, 1, 0, 2'b00, 2'b00, 16'd1);
        cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd2);
        nop(); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd2);
`endif

        // ALU RAW: ADD R2, then SUB R6,R7,R2
        rstPulse();
        idIn(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        idIn(1, 7, 2, 1, 1, 6, 1, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        nop(); cy(1, 0, 1, 0, 0, 2'b00, 2'b01, 16'd0);
        cy(0, 0, 0, 0, 0, 2'b00, 2'b01, 16'd0);
        cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
`else
        cy(0, 0, 1, 1, 0, 2'b00, 2'b00, 16'd0);
        cy(0, 0, 1, 1, 0, 2'b00, 2'b00, 16'd1);
        cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd2);
        nop(); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd2);
`endif

        // Register 0 never hazards
        rstPulse();
        idIn(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        idIn(1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        nop(); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);

        // Matching source that is not read: no load-use stall
        rstPulse();
        idIn(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        idIn(1, 9, 9, 0, 0, 5, 1, 0, 0, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);

        // Flags: ADD setflags, then taken conditional branch
        rstPulse();
        idIn(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        idIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); cy(0, 0, 1, 1, 0, 2'b00, 2'b00, 16'd0);
        cy(0, 0, 0, 0, 1, 2'b00, 2'b00, 16'd1);
        nop(); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd1);

        // Freeze for 3 cycles over a load-use, then the 1-cycle hazard
        rstPulse();
        idIn(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        idIn(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 1);
        cy(1, 0, 1, 0, 0, 2'b00, 2'b00, 16'd0);
        cy(1, 0, 1, 0, 0, 2'b00, 2'b00, 16'd0);
        cy(1, 0, 1, 0, 0, 2'b00, 2'b00, 16'd0);
        idIn(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0);
        cy(0, 0, 1, 1, 0, 2'b00, 2'b00, 16'd0);
`ifdef HAZARD_FWD_EN
        cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd1);
        nop(); cy(0, 0, 0, 0, 0, 2'b10, 2'b00, 16'd1);
`else
        cy(0, 0, 1, 1, 0, 2'b00, 2'b00, 16'd1);
        cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd2);
        nop(); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd2);
`endif

        // Reset during a hazard cycle discards the pending load
        rstPulse();
        idIn(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        idIn(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0); cy(0, 1, 1, 1, 0, 2'b00, 2'b00, 16'd0);
        cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);
        nop(); cy(0, 0, 0, 0, 0, 2'b00, 2'b00, 16'd0);

        repeat (3) @(posedge clk);
        check("queue_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
